// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - Sv39 PTE field layout and PTW responder state encoding shared with the MMU
package mmu_pkg;

   localparam int PTE_V       = 0;
   localparam int PTE_R       = 1;
   localparam int PTE_W       = 2;
   localparam int PTE_X       = 3;
   localparam int PTE_U       = 4;
   localparam int PTE_G       = 5;
   localparam int PTE_A       = 6;
   localparam int PTE_D       = 7;
   localparam int PTE_PPN_LSB = 10;
   localparam int PTE_PPN_MSB = 53;
   localparam int PTE_BYTES   = 8;
   localparam int PTE_OFS_W   = $clog2(PTE_BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_BUS_REQ,
      S_BUS_WAIT,
      S_RESP,
      S_DRAIN
   } ptw_resp_state_t;

   function automatic logic pte_aligned(input logic [PTE_OFS_W-1:0] ofs);
      return ofs == '0;
   endfunction

endpackage

// File: rtl/pte_cache.sv
// rtl/pte_cache.sv - fully-associative PTE cache with round-robin fill and single-cycle flush
module pte_cache #(
   parameter int ENTRIES = 4,
   parameter int TAG_W   = 61,
   parameter int DATA_W  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [TAG_W-1:0]  lookup_tag,
   output logic              lookup_hit,
   output logic [DATA_W-1:0] lookup_data,
   input  logic              fill_en,
   input  logic [TAG_W-1:0]  fill_tag,
   input  logic [DATA_W-1:0] fill_data,
   input  logic              flush
);
   localparam int PTR_W = $clog2(ENTRIES);

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q  [ENTRIES];
   logic [TAG_W-1:0]   tag_d  [ENTRIES];
   logic [DATA_W-1:0]  data_q [ENTRIES];
   logic [DATA_W-1:0]  data_d [ENTRIES];
   logic [PTR_W-1:0]   ptr_q, ptr_d;

   // Fills only happen on a miss, so at most one entry can match.
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && tag_q[i] == lookup_tag) begin
            lookup_hit  = 1'b1;
            lookup_data = data_q[i];
         end
      end
   end

   // Flush beats a coincident fill: nothing is written and the pointer holds.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      ptr_d   = ptr_q;
      if (flush) begin
         valid_d = '0;
      end else if (fill_en) begin
         valid_d[ptr_q] = 1'b1;
         tag_d[ptr_q]   = fill_tag;
         data_d[ptr_q]  = fill_data;
         ptr_d          = ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         ptr_q   <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/ptw_mem_responder.sv
// rtl/ptw_mem_responder.sv - serves MMU page-table-walk PTE reads from a PTE cache or the memory bus
module ptw_mem_responder
   import mmu_pkg::*;
#(
   parameter int PADDR_WIDTH    = 64,
   parameter int DATA_WIDTH     = 64,
   parameter int CACHE_ENTRIES  = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ptw_req,
   input  logic [PADDR_WIDTH-1:0] ptw_addr,
   output logic [DATA_WIDTH-1:0]  ptw_data,
   output logic                   ptw_ready,
   input  logic                   ptw_flush,
   output logic                   mem_req_valid,
   input  logic                   mem_req_ready,
   output logic [PADDR_WIDTH-1:0] mem_req_addr,
   input  logic                   mem_resp_valid,
   input  logic [DATA_WIDTH-1:0]  mem_resp_data,
   input  logic                   mem_resp_err,
   output logic                   timeout_err,
   output logic                   protocol_err
);
   localparam int TAG_W = PADDR_WIDTH - PTE_OFS_W;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   ptw_resp_state_t        state_q, state_d;
   logic [DATA_WIDTH-1:0]  ptw_data_q, ptw_data_d;
   logic                   ptw_ready_q, ptw_ready_d;
   logic                   mem_req_valid_q, mem_req_valid_d;
   logic [PADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
   logic                   timeout_err_q, timeout_err_d;
   logic                   protocol_err_q, protocol_err_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   drain_q, drain_d;

   logic                   hit;
   logic [DATA_WIDTH-1:0]  hit_data;
   logic                   fill_en;
   logic                   resp_set;
   logic [DATA_WIDTH-1:0]  resp_val;

   pte_cache #(
      .ENTRIES (CACHE_ENTRIES),
      .TAG_W   (TAG_W),
      .DATA_W  (DATA_WIDTH)
   ) u_cache (
      .clk         (clk),
      .rst         (rst),
      .lookup_tag  (ptw_addr[PADDR_WIDTH-1:PTE_OFS_W]),
      .lookup_hit  (hit),
      .lookup_data (hit_data),
      .fill_en     (fill_en),
      .fill_tag    (mem_req_addr_q[PADDR_WIDTH-1:PTE_OFS_W]),
      .fill_data   (mem_resp_data),
      .flush       (ptw_flush)
   );

   always_comb begin
      state_d         = state_q;
      ptw_data_d      = ptw_data_q;
      ptw_ready_d     = 1'b0;
      mem_req_addr_d  = mem_req_addr_q;
      timeout_err_d   = 1'b0;
      protocol_err_d  = protocol_err_q | (ptw_req && state_q != S_IDLE);
      cnt_d           = cnt_q;
      drain_d         = drain_q;
      fill_en         = 1'b0;
      resp_set        = 1'b0;
      resp_val        = '0;

      case (state_q)
         S_IDLE: begin
            if (ptw_req) state_d = S_ADDR;
         end
         S_ADDR: begin
            // A flush this cycle makes the lookup miss rather than return a dying entry.
            if (!pte_aligned(ptw_addr[PTE_OFS_W-1:0])) begin
               resp_set = 1'b1;
            end else if (hit && !ptw_flush) begin
               resp_set = 1'b1;
               resp_val = hit_data;
            end else begin
               state_d        = S_BUS_REQ;
               mem_req_addr_d = ptw_addr;
               cnt_d          = '0;
               drain_d        = 1'b0;
            end
         end
         S_BUS_REQ: begin
            if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
            if (mem_req_ready) begin
               state_d = S_BUS_WAIT;
            end else if (cnt_q == CNT_LAST) begin
               resp_set      = 1'b1;
               timeout_err_d = 1'b1;
            end
         end
         S_BUS_WAIT: begin
            if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
            if (mem_resp_valid) begin
               resp_set = 1'b1;
               fill_en  = !mem_resp_err;
               resp_val = mem_resp_err ? '0 : mem_resp_data;
            end else if (cnt_q == CNT_LAST) begin
               // The beat is still owed by the bus; swallow it in DRAIN later.
               resp_set      = 1'b1;
               timeout_err_d = 1'b1;
               drain_d       = 1'b1;
            end
         end
         S_RESP: begin
            state_d = drain_q ? S_DRAIN : S_IDLE;
         end
         S_DRAIN: begin
            if (mem_resp_valid) begin
               state_d = S_IDLE;
               drain_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (resp_set) begin
         state_d     = S_RESP;
         ptw_ready_d = 1'b1;
         ptw_data_d  = resp_val;
      end
      mem_req_valid_d = (state_d == S_BUS_REQ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         ptw_data_q      <= '0;
         ptw_ready_q     <= 1'b0;
         mem_req_valid_q <= 1'b0;
         mem_req_addr_q  <= '0;
         timeout_err_q   <= 1'b0;
         protocol_err_q  <= 1'b0;
         cnt_q           <= '0;
         drain_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         ptw_data_q      <= ptw_data_d;
         ptw_ready_q     <= ptw_ready_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_req_addr_q  <= mem_req_addr_d;
         timeout_err_q   <= timeout_err_d;
         protocol_err_q  <= protocol_err_d;
         cnt_q           <= cnt_d;
         drain_q         <= drain_d;
      end
   end

   assign ptw_data      = ptw_data_q;
   assign ptw_ready     = ptw_ready_q;
   assign mem_req_valid = mem_req_valid_q;
   assign mem_req_addr  = mem_req_addr_q;
   assign timeout_err   = timeout_err_q;
   assign protocol_err  = protocol_err_q;

endmodule

// File: tb/tb_ptw_mem_responder.sv
// tb/tb_ptw_mem_responder.sv - scoreboard bench for ptw_mem_responder
module tb_ptw_mem_responder;
   import mmu_pkg::*;

   localparam int TO = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        ptw_req;
   logic [63:0] ptw_addr;
   logic [63:0] ptw_data;
   logic        ptw_ready;
   logic        ptw_flush;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_data;
   logic        mem_resp_err;
   logic        timeout_err;
   logic        protocol_err;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          t_req = 0;
   int          req_cycles = 0;
   logic [63:0] exp_q[$];

   bit          bus_respond = 1'b1;
   bit          bus_err = 1'b0;
   bit          force_resp = 1'b0;
   bit          pending = 1'b0;
   logic [63:0] pend_addr = '0;

   ptw_mem_responder dut (
      .clk            (clk),
      .rst            (rst),
      .ptw_req        (ptw_req),
      .ptw_addr       (ptw_addr),
      .ptw_data       (ptw_data),
      .ptw_ready      (ptw_ready),
      .ptw_flush      (ptw_flush),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .mem_resp_err   (mem_resp_err),
      .timeout_err    (timeout_err),
      .protocol_err   (protocol_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] pte_mk(input logic [43:0] ppn);
      logic [63:0] d;
      d = '0;
      d[PTE_PPN_MSB:PTE_PPN_LSB] = ppn;
      d[PTE_V] = 1'b1; d[PTE_R] = 1'b1; d[PTE_W] = 1'b1; d[PTE_X] = 1'b1;
      d[PTE_U] = 1'b0; d[PTE_G] = 1'b0; d[PTE_A] = 1'b1; d[PTE_D] = 1'b1;
      return d;
   endfunction

   function automatic logic [63:0] mem_of(input logic [63:0] a);
      if (a == 64'h8000_1008) return pte_mk(44'h8_0001);
      return a ^ 64'h5A5A_0000_0000_00CF;
   endfunction

   // Memory bus model: answers one cycle after an accepted request.
   always @(negedge clk) begin
      mem_resp_valid = 1'b0;
      mem_resp_err   = 1'b0;
      if (pending || force_resp) begin
         mem_resp_valid = 1'b1;
         mem_resp_err   = pending ? bus_err : 1'b0;
         mem_resp_data  = pending ? mem_of(pend_addr) : 64'hDEAD_BEEF_0000_0001;
         pending    = 1'b0;
         force_resp = 1'b0;
      end
      if (mem_req_valid && mem_req_ready && bus_respond && !rst) begin
         pending   = 1'b1;
         pend_addr = mem_req_addr;
      end
   end

   // Scoreboard: every ptw_ready pulse consumes one expected PTE.
   always @(negedge clk) begin
      if (!rst && mem_req_valid) req_cycles++;
      if (!rst && ptw_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_ready: got ptw_data=%h with nothing expected", ptw_data);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if (ptw_data !== e) begin
               errors++;
               $display("FAIL sb_ptw_data: got %h expected %h", ptw_data, e);
            end
         end
      end
   end

   task automatic issue(input logic [63:0] a);
      @(negedge clk);
      ptw_req = 1'b1;
      t_req   = cyc;
      @(negedge clk);
      ptw_req  = 1'b0;
      ptw_addr = a;
   endtask

   task automatic wait_ready(input int budget, output int lat);
      lat = -1;
      for (int i = 0; i < budget; i++) begin
         if (ptw_ready) begin
            lat = cyc - t_req;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (ptw_ready !== 1'b0)     begin errors++; $display("FAIL reset_ptw_ready: got %b expected 0", ptw_ready); end
      checks++; if (ptw_data !== 64'h0)     begin errors++; $display("FAIL reset_ptw_data: got %h expected 0", ptw_data); end
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b expected 0", mem_req_valid); end
      checks++; if (mem_req_addr !== 64'h0) begin errors++; $display("FAIL reset_mem_req_addr: got %h expected 0", mem_req_addr); end
      checks++; if (timeout_err !== 1'b0)   begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
      checks++; if (protocol_err !== 1'b0)  begin errors++; $display("FAIL reset_protocol_err: got %b expected 0", protocol_err); end
      rst = 1'b0;
   endtask

   task automatic test_miss();
      int lat;
      int rc;
      mem_req_ready = 1'b1; bus_respond = 1'b1; bus_err = 1'b0;
      exp_q.push_back(64'h2000_04CF);
      issue(64'h8000_1008);
      rc = -1;
      for (int i = 0; i < 10; i++) begin
         if (mem_req_valid) begin rc = cyc - t_req; break; end
         @(negedge clk);
      end
      checks++; if (rc !== 2) begin errors++; $display("FAIL miss_req_latency: got %0d expected 2", rc); end
      checks++; if (mem_req_addr !== 64'h8000_1008) begin errors++; $display("FAIL miss_req_addr: got %h expected 80001008", mem_req_addr); end
      wait_ready(10, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL miss_ready_latency: got %0d expected 4", lat); end
      repeat (5) @(negedge clk);
      checks++; if (ptw_data !== 64'h2000_04CF) begin errors++; $display("FAIL miss_data_held: got %h expected 200004cf", ptw_data); end
   endtask

   task automatic test_hit();
      int lat;
      int rc0;
      rc0 = req_cycles;
      exp_q.push_back(64'h2000_04CF);
      issue(64'h8000_1008);
      wait_ready(10, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL hit_latency: got %0d expected 2", lat); end
      checks++; if (req_cycles !== rc0) begin errors++; $display("FAIL hit_no_bus: got %0d req cycles expected %0d", req_cycles, rc0); end
   endtask

   task automatic test_replacement();
      logic [63:0] a [5];
      int lat;
      for (int i = 0; i < 5; i++) a[i] = 64'h8000_A000 + 64'(i) * 64'h40;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(mem_of(a[i]));
         issue(a[i]);
         wait_ready(10, lat);
         checks++; if (lat !== 4) begin errors++; $display("FAIL repl_fill_%0d: got latency %0d expected 4", i, lat); end
      end
      for (int i = 1; i < 5; i++) begin
         exp_q.push_back(mem_of(a[i]));
         issue(a[i]);
         wait_ready(10, lat);
         checks++; if (lat !== 2) begin errors++; $display("FAIL repl_hit_%0d: got latency %0d expected 2", i, lat); end
      end
      exp_q.push_back(mem_of(a[0]));
      issue(a[0]);
      wait_ready(10, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL repl_evicted: got latency %0d expected 4", lat); end
   endtask

   task automatic test_errors();
      int lat;
      int rc0;
      bus_err = 1'b1;
      exp_q.push_back(64'h0);
      issue(64'h8000_2000);
      wait_ready(10, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL err_latency: got %0d expected 4", lat); end
      bus_err = 1'b0;
      rc0 = req_cycles;
      exp_q.push_back(mem_of(64'h8000_2000));
      issue(64'h8000_2000);
      wait_ready(10, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL err_no_fill: got latency %0d expected 4", lat); end
      checks++; if (req_cycles === rc0) begin errors++; $display("FAIL err_refetch_bus: got %0d req cycles expected more than %0d", req_cycles, rc0); end
      rc0 = req_cycles;
      exp_q.push_back(64'h0);
      issue(64'h8000_1004);
      wait_ready(10, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL misalign_latency: got %0d expected 2", lat); end
      checks++; if (req_cycles !== rc0) begin errors++; $display("FAIL misalign_no_bus: got %0d req cycles expected %0d", req_cycles, rc0); end
   endtask

   task automatic test_timeout_req();
      int lat;
      mem_req_ready = 1'b0;
      exp_q.push_back(64'h0);
      issue(64'h8000_3000);
      wait_ready(TO + 50, lat);
      checks++; if (lat !== TO + 2) begin errors++; $display("FAIL to_req_latency: got %0d expected %0d", lat, TO + 2); end
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_req_pulse: got %b expected 1", timeout_err); end
      @(negedge clk);
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL to_req_drop: got %b expected 0", mem_req_valid); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_req_one_cycle: got %b expected 0", timeout_err); end
      mem_req_ready = 1'b1;
   endtask

   task automatic test_timeout_drain();
      int lat;
      bus_respond = 1'b0;
      exp_q.push_back(64'h0);
      issue(64'h8000_4000);
      wait_ready(TO + 50, lat);
      checks++; if (lat !== TO + 2) begin errors++; $display("FAIL to_wait_latency: got %0d expected %0d", lat, TO + 2); end
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_wait_pulse: got %b expected 1", timeout_err); end
      repeat (5) @(negedge clk);
      force_resp = 1'b1;
      repeat (4) @(negedge clk);
      bus_respond = 1'b1;
      exp_q.push_back(mem_of(64'h8000_4000));
      issue(64'h8000_4000);
      wait_ready(10, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL drain_no_fill: got latency %0d expected 4", lat); end
   endtask

   task automatic test_reset_mid();
      int lat;
      bus_respond = 1'b0;
      issue(64'h8000_6000);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_req_valid: got %b expected 0", mem_req_valid); end
      checks++; if (ptw_ready !== 1'b0)     begin errors++; $display("FAIL rstmid_ptw_ready: got %b expected 0", ptw_ready); end
      @(negedge clk);
      rst = 1'b0;
      force_resp = 1'b1;
      repeat (4) @(negedge clk);
      bus_respond = 1'b1;
      exp_q.push_back(mem_of(64'h8000_6000));
      issue(64'h8000_6000);
      wait_ready(10, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL rstmid_recover: got latency %0d expected 4", lat); end
   endtask

   task automatic test_protocol_err();
      int lat;
      checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL proto_initial: got %b expected 0", protocol_err); end
      exp_q.push_back(mem_of(64'h8000_7000));
      issue(64'h8000_7000);
      @(negedge clk);
      ptw_req = 1'b1;
      @(negedge clk);
      ptw_req = 1'b0;
      wait_ready(10, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL proto_ignored: got latency %0d expected 4", lat); end
      checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL proto_set: got %b expected 1", protocol_err); end
      repeat (20) @(negedge clk);
      checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b expected 1", protocol_err); end
      pulse_reset();
      checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL proto_cleared: got %b expected 0", protocol_err); end
   endtask

   task automatic test_flush_fill();
      int lat;
      exp_q.push_back(mem_of(64'h8000_5000));
      issue(64'h8000_5000);
      @(negedge clk);
      @(negedge clk);
      ptw_flush = 1'b1;
      @(negedge clk);
      ptw_flush = 1'b0;
      wait_ready(10, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL flush_first: got latency %0d expected 4", lat); end
      exp_q.push_back(mem_of(64'h8000_5000));
      issue(64'h8000_5000);
      wait_ready(10, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL flush_beats_fill: got latency %0d expected 4", lat); end
      exp_q.push_back(mem_of(64'h8000_5000));
      issue(64'h8000_5000);
      wait_ready(10, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL flush_refilled: got latency %0d expected 2", lat); end
      @(negedge clk);
      ptw_flush = 1'b1;
      @(negedge clk);
      ptw_flush = 1'b0;
      exp_q.push_back(mem_of(64'h8000_5000));
      issue(64'h8000_5000);
      wait_ready(10, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL flush_idle: got latency %0d expected 4", lat); end
   endtask

   initial begin
      rst = 1'b1; ptw_req = 1'b0; ptw_addr = '0; ptw_flush = 1'b0;
      mem_req_ready = 1'b1;
      test_reset();
      test_miss();
      test_hit();
      test_replacement();
      test_errors();
      test_timeout_req();
      test_timeout_drain();
      test_reset_mid();
      test_protocol_err();
      test_flush_fill();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d pending responses expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
